// File: rtl/fu_lock_arbiter.sv
// Lock arbiter guarding one shared function unit: priority/round-robin grant,
// owner-only op forwarding and reply return, watchdog revoke of idle owners.

module fu_lock_node_dec #(
    parameter logic [3:0] TAG = 4'hD
) (
    input  logic [15:0] i_op,
    output logic        o_req,
    output logic [3:0]  o_prio,
    output logic        o_rel
);
    assign o_req  = (i_op[15:12] == 4'hF) && (i_op[11:8] == TAG) &&
                    (i_op[7:4] == 4'h0) && (i_op[3:0] != 4'h0);
    assign o_prio = i_op[3:0];
    assign o_rel  = (i_op == {4'hF, TAG, 8'hFF});
endmodule

module fu_lock_arbiter #(
    parameter int unsigned NODES   = 4,
    parameter logic [3:0]  TAG     = 4'hD,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] in_op_node0,
    input  logic [15:0] in_op_node1,
    input  logic [15:0] in_op_node2,
    input  logic [15:0] in_op_node3,
    output logic [15:0] out_node0,
    output logic [15:0] out_node1,
    output logic [15:0] out_node2,
    output logic [15:0] out_node3,
    output logic [15:0] res_op,
    input  logic [15:0] res_out,
    output logic [3:0]  grant,
    output logic        timeout_evt
);
    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [3:0]  NODE_MASK = 4'((1 << NODES) - 1);
    localparam logic [15:0] ABORT_W   = {4'hE, TAG, 8'hFF};
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

    logic [3:0][15:0] w_in;
    logic [3:0]       w_req_raw, w_req, w_rel;
    logic [3:0][3:0]  w_prio;

    state_t           r_state, w_state_nx;
    logic [1:0]       r_owner, w_owner_nx, r_rr, w_rr_nx, w_rr_after;
    logic [15:0]      r_wd, w_wd_nx, r_prev, w_prev_nx, r_res_op, w_res_op_nx;
    logic [3:0][15:0] r_out, w_out_nx;
    logic [3:0]       r_grant, w_grant_nx;
    logic             r_tevt, w_tevt_nx;

    logic             w_win_vld;
    logic [1:0]       w_win;
    logic [3:0]       w_best;
    logic [2:0]       w_idx;
    logic [15:0]      w_own_op;

    assign w_in = {in_op_node3, in_op_node2, in_op_node1, in_op_node0};

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_dec
        fu_lock_node_dec #(.TAG(TAG)) u_dec (
            .i_op   (w_in[gi]),
            .o_req  (w_req_raw[gi]),
            .o_prio (w_prio[gi]),
            .o_rel  (w_rel[gi])
        );
    end

    assign w_req = w_req_raw & NODE_MASK;

    // Scan from rr_ptr with a strict '>' so the first tied node at or after rr_ptr wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        w_best    = '0;
        w_idx     = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(NODES)) begin
                w_idx = {1'b0, r_rr} + 3'(k);
                if (w_idx >= 3'(NODES)) w_idx = w_idx - 3'(NODES);
                if (w_req[w_idx[1:0]] && (w_prio[w_idx[1:0]] > w_best)) begin
                    w_win_vld = 1'b1;
                    w_win     = w_idx[1:0];
                    w_best    = w_prio[w_idx[1:0]];
                end
            end
        end
    end

    assign w_own_op   = w_in[r_owner];
    assign w_rr_after = (r_owner == 2'(NODES - 1)) ? 2'd0 : r_owner + 2'd1;

    always_comb begin
        w_state_nx  = r_state;
        w_owner_nx  = r_owner;
        w_rr_nx     = r_rr;
        w_wd_nx     = r_wd;
        w_prev_nx   = r_prev;
        w_res_op_nx = '0;
        w_out_nx    = '0;
        w_grant_nx  = '0;
        w_tevt_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nx        = OWNED;
                    w_owner_nx        = w_win;
                    w_grant_nx[w_win] = 1'b1;
                    w_out_nx[w_win]   = {4'hF, TAG, 4'h1, 2'b00, w_win};
                    w_wd_nx           = '0;
                    w_prev_nx         = w_in[w_win];
                end
            end
            OWNED: begin
                w_prev_nx = w_own_op;
                if (w_rel[r_owner]) begin
                    w_state_nx = IDLE;
                    w_rr_nx    = w_rr_after;
                end else if ((w_own_op == r_prev) && (r_wd == WD_LAST)) begin
                    w_state_nx        = IDLE;
                    w_rr_nx           = w_rr_after;
                    w_out_nx[r_owner] = ABORT_W;
                    w_tevt_nx         = 1'b1;
                end else begin
                    w_grant_nx = r_grant;
                    if (w_own_op != r_prev) w_wd_nx = '0;
                    else if (r_wd != 16'hFFFF) w_wd_nx = r_wd + 16'd1;
                    // A repeated REQ from the owner is only a keepalive.
                    if (!w_req[r_owner]) begin
                        w_res_op_nx       = w_own_op;
                        w_out_nx[r_owner] = res_out;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr     <= '0;
            r_wd     <= '0;
            r_prev   <= '0;
            r_res_op <= '0;
            r_out    <= '0;
            r_grant  <= '0;
            r_tevt   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_owner  <= w_owner_nx;
            r_rr     <= w_rr_nx;
            r_wd     <= w_wd_nx;
            r_prev   <= w_prev_nx;
            r_res_op <= w_res_op_nx;
            r_out    <= w_out_nx;
            r_grant  <= w_grant_nx;
            r_tevt   <= w_tevt_nx;
        end
    end

    assign out_node0   = NODE_MASK[0] ? r_out[0] : 16'h0;
    assign out_node1   = NODE_MASK[1] ? r_out[1] : 16'h0;
    assign out_node2   = NODE_MASK[2] ? r_out[2] : 16'h0;
    assign out_node3   = NODE_MASK[3] ? r_out[3] : 16'h0;
    assign res_op      = r_res_op;
    assign grant       = r_grant;
    assign timeout_evt = r_tevt;
endmodule
